seq_signed_divider: RTL and testbench
=====================================

# seq_signed_divider

Iterative signed divider. It takes a 2N-bit accumulated value, such as a multiply-accumulate result, and divides it by an N-bit signed divisor, producing a 2N-bit quotient and an N-bit remainder. It is the counterpart to the accumulator path: it scales accumulated sums back down, for example when normalising or averaging. The block computes one quotient bit per clock using restoring division on magnitudes, with ready/valid handshakes on both sides.

## Interface
- N, default 8: divisor and remainder width; dividend and quotient are 2N bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block idle and able to accept operands.
- dividend  in  2N  signed dividend.
- divisor  in  N  signed divisor.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer accepts the result.
- quotient  out  2N  signed quotient, truncated toward zero.
- remainder  out  N  signed remainder; takes the sign of the dividend.
- div_by_zero  out  1  result came from divisor == 0.
- overflow  out  1  result came from dividend == -2^(2N-1) with divisor == -1.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: 2N iterations.
  - FIX: sign correction.
  - DONE: out_valid=1.
- Accept occurs on an edge where in_valid && in_ready. On accept, the block:
  - latches the magnitude of the dividend (2N bits unsigned) and the magnitude of the divisor (N bits unsigned; |-2^(N-1)| = 2^(N-1) fits);
  - latches sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend);
  - clears the partial remainder (N+1 bits) and the iteration counter.
- Operand changes after accept are ignored.
- If divisor == 0 at accept, the block goes straight to DONE with quotient=0, remainder=0, div_by_zero=1, overflow=0. No iterations are run.
- Each CALC cycle:
  - shift {partial remainder, dividend magnitude} left by 1;
  - trial = partial remainder − divisor magnitude;
  - if trial ≥ 0, keep trial and shift in quotient bit 1; otherwise restore and shift in 0;
  - the counter increments and reaches 2N−1 on the last iteration, after which the state goes to FIX.
- FIX:
  - quotient = sign_q ? −q_mag : q_mag, taken mod 2^(2N);
  - remainder = sign_r ? −r_mag : r_mag;
  - |remainder| < |divisor| ≤ 2^(N−1), so the remainder always fits in N bits;
  - overflow = (dividend was −2^(2N−1) and divisor was −1). The quotient then wraps to −2^(2N−1), and the remainder is 0.
- DONE:
  - holds quotient, remainder and flags stable while out_ready=0;
  - goes to IDLE on out_valid && out_ready;
  - in_ready=0 throughout, and in_valid is ignored.
- Outputs keep their last values in IDLE. Flags are cleared at the next accept.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0;
  - quotient=0, remainder=0, div_by_zero=0, overflow=0;
  - all internal registers 0.
- Reset mid-operation (any state) aborts the division immediately. There is no stale out_valid after release.
- in_ready and out_valid are decoded from registered state, with no combinational path from inputs.
- Normal latency:
  - accept on edge E0;
  - CALC on edges E1..E2N;
  - FIX on E2N+1;
  - out_valid is high from E2N+1 onward. For N=8 it is visible 17 cycles after accept.
- Divide-by-zero latency: out_valid is high after E1.
- Result handshake on edge Ek sets out_valid=0 and in_ready=1 after Ek. The earliest next accept is Ek+1.
- Peak throughput: one division per 2N+3 cycles (19 for N=8).
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes; the input waits.

## Test plan
- 1000 / 7, out_ready=1 → quotient=142, remainder=6, flags 0; out_valid rises exactly 17 cycles after accept and is high for 1 cycle.
- Sign combinations:
  - −1000/7 → −142, −6;
  - 1000/−7 → −142, 6;
  - −1000/−7 → 142, −6;
  - 32767/−128 → −255, 127;
  - 3/100 → 0, 3.
- 5 / 0 → div_by_zero=1, quotient=0, remainder=0, out_valid one cycle after accept. Following 100/10 → 10, 0 with div_by_zero=0.
- −32768 / −1 → quotient=0x8000 (−32768), remainder=0, overflow=1. Following 32767/1 → 32767, 0, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with new operands → outputs stable, in_ready=0, nothing accepted. out_ready=1 → handshake, then accept on the next cycle.
- Assert rst at iteration 5 of 1000/7 → all outputs 0 and in_ready=1 immediately, no out_valid. Release, then 100/10 → 10, 0 with normal 17-cycle latency.

Source files
------------

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: a 2N-bit dividend over an N-bit divisor, one quotient bit per clock.
// Division runs on operand magnitudes; a final FIX cycle applies the signs to the quotient and remainder.
module seq_signed_divider #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] LAST_ITER = CW'(2 * N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2*N-1:0] r_dvd;       // dividend magnitude, shifted out as quotient bits shift in
    logic [N-1:0]   r_dsr;
    logic [N:0]     r_rem;
    logic [CW-1:0]  r_cnt;
    logic           r_sign_q;
    logic           r_sign_r;
    logic           r_dbz;
    logic           r_ovf;

    logic           w_accept;
    logic           w_zero;
    logic           w_ovf_case;
    logic [2*N-1:0] w_dvd_mag;
    logic [N-1:0]   w_dsr_mag;
    logic [N+1:0]   w_shift;
    logic [N+1:0]   w_diff;
    logic           w_ge;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_zero     = (divisor == '0);
    assign w_ovf_case = (dividend == {1'b1, {(2*N-1){1'b0}}}) && (divisor == '1);
    assign w_dvd_mag  = dividend[2*N-1] ? -dividend : dividend;
    assign w_dsr_mag  = divisor[N-1] ? -divisor : divisor;

    // Restoring step: a set borrow bit means the trial subtraction went negative.
    assign w_shift = {r_rem, r_dvd[2*N-1]};
    assign w_diff  = w_shift - {2'b00, r_dsr};
    assign w_ge    = ~w_diff[N+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_zero ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == LAST_ITER) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:   w_state_next = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // A zero divisor skips CALC; a cleared magnitude makes FIX yield 0 / 0.
                        r_dvd       <= w_zero ? '0 : w_dvd_mag;
                        r_dsr       <= w_dsr_mag;
                        r_rem       <= '0;
                        r_cnt       <= '0;
                        r_sign_q    <= dividend[2*N-1] ^ divisor[N-1];
                        r_sign_r    <= dividend[2*N-1];
                        r_dbz       <= w_zero;
                        r_ovf       <= w_ovf_case;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_diff[N:0] : w_shift[N:0];
                    r_dvd <= {r_dvd[2*N-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    // The overflow case wraps naturally: |min| / 1 with positive sign gives min.
                    quotient    <= r_sign_q ? -r_dvd : r_dvd;
                    remainder   <= r_sign_r ? -r_rem[N-1:0] : r_rem[N-1:0];
                    div_by_zero <= r_dbz;
                    overflow    <= r_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider (N=8): the driver pushes expected results computed with
// plain integer division, and an independent monitor checks every result handshake, latency and stability.
module tb_seq_signed_divider;

    localparam int N = 8;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2*N-1:0]  dividend;
    logic [N-1:0]    divisor;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  quotient;
    logic [N-1:0]    remainder;
    logic            div_by_zero;
    logic            overflow;

    logic            man_rdy;
    logic            rnd_mode;
    logic            rnd_bit;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          a;
        int          b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    seq_signed_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign out_ready = rnd_mode ? rnd_bit : man_rdy;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: truncating signed division on wide integers, wrapped to the output widths.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        longint q;
        int r;
        e.a = a;
        e.b = b;
        e.lat = 17;
        e.acc = 0;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == 0) begin
            e.q = '0;
            e.r = '0;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            q = longint'(a) / longint'(b);
            r = a % b;
            e.q = q[15:0];
            e.r = r[7:0];
            e.ovf = (a == -32768) && (b == -1);
        end
        return e;
    endfunction

    // Monitor: all checks on DUT results happen here, on the falling edge.
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [15:0] pq;
    logic [7:0]  pr;
    logic        pdbz;
    logic        povf;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) begin
                chk("post_hs_out_valid", out_valid == 1'b0, out_valid, 0);
                chk("post_hs_in_ready", in_ready == 1'b1, in_ready, 1);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1'b0, out_valid, 0);
                end else begin
                    if (!prev_valid)
                        chk("latency", (cyc - sb[0].acc) == sb[0].lat, cyc - sb[0].acc, sb[0].lat);
                    if (prev_valid && !prev_hs) begin
                        chk("hold_quotient", quotient == pq, quotient, pq);
                        chk("hold_flags", {remainder, div_by_zero, overflow} == {pr, pdbz, povf},
                            {remainder, div_by_zero, overflow}, {pr, pdbz, povf});
                        chk("done_in_ready", in_ready == 1'b0, in_ready, 0);
                    end
                    if (out_ready) begin
                        chk("quotient", quotient == sb[0].q, $signed(quotient), $signed(sb[0].q));
                        chk("remainder", remainder == sb[0].r, $signed(remainder), $signed(sb[0].r));
                        chk("div_by_zero", div_by_zero == sb[0].dbz, div_by_zero, sb[0].dbz);
                        chk("overflow", overflow == sb[0].ovf, overflow, sb[0].ovf);
                        $display("txn %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b", sb[0].a, sb[0].b,
                                 $signed(quotient), $signed(remainder), div_by_zero, overflow);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
            prev_hs = out_valid && out_ready;
            pq = quotient;
            pr = remainder;
            pdbz = div_by_zero;
            povf = overflow;
        end
    end

    // Present operands, wait (bounded) for acceptance, then scramble the operand bus.
    task automatic do_div(input int a, input int b);
        exp_t e;
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        dividend = a[15:0];
        divisor = b[7:0];
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 1'b0, n, 0);
        end else begin
            e = model(a, b);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("idle_timeout", 1'b0, sb.size(), 0);
    endtask

    function automatic int pick_dividend();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 7))
            0: return -32768;
            1: return 32767;
            default: return int'($signed(v));
        endcase
    endfunction

    function automatic int pick_divisor();
        logic [7:0] v;
        v = 8'($urandom);
        case ($urandom_range(0, 9))
            0: return 0;
            1: return -1;
            2: return -128;
            3: return 1;
            default: return int'($signed(v));
        endcase
    endfunction

    initial begin
        int n;
        exp_t e;
        rst = 1'b1;
        in_valid = 1'b0;
        dividend = '0;
        divisor = '0;
        man_rdy = 1'b1;
        rnd_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready == 1'b1, in_ready, 1);
        chk("reset_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("reset_outputs", {quotient, remainder, div_by_zero, overflow} == '0,
            {quotient, remainder, div_by_zero, overflow}, 0);
        rst = 1'b0;

        // Directed cases, including sign combinations, zero divisor and overflow.
        do_div(1000, 7);
        do_div(-1000, 7);
        do_div(1000, -7);
        do_div(-1000, -7);
        do_div(32767, -128);
        do_div(3, 100);
        do_div(5, 0);
        do_div(100, 10);
        do_div(-32768, -1);
        do_div(32767, 1);
        wait_idle();

        // Backpressure: new operands must wait while the result is held.
        man_rdy = 1'b0;
        do_div(-1000, 7);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", out_valid == 1'b1, out_valid, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        dividend = 16'd55;
        divisor = 8'd5;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready == 1'b0, in_ready, 0);
        end
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_in_ready", in_ready == 1'b1, in_ready, 1);
        e = model(55, 5);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a division.
        do_div(1000, 7);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready == 1'b1, in_ready, 1);
        chk("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("midrst_outputs", {quotient, remainder, div_by_zero, overflow} == '0,
            {quotient, remainder, div_by_zero, overflow}, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        do_div(100, 10);
        wait_idle();

        // Randomized operands with random consumer backpressure.
        rnd_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            do_div(pick_dividend(), pick_divisor());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
        end
        wait_idle();
        rnd_mode = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
